// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command opcodes, system sub-commands, frame headers and TX FSM state encoding
package uart_cmd_pkg;
  localparam logic [1:0] OP_TGL = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_SYS = 2'b11;
  localparam logic [5:0] SYS_ALL_OFF = 6'h00, SYS_ALL_ON = 6'h01, SYS_REPORT = 6'h02;
  localparam logic [7:0] HDR_CNT = 8'h5A, HDR_RPT = 8'hA5;
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO} tx_state_t;
endpackage

// File: rtl/uart_sec_tick.sv
// uart_sec_tick: prescaler + seconds counter; in clk_50m/reset_n, out tick (1-cycle pulse every CLK_DIV cycles) and count (CNT_BYTES*8-bit wrapping seconds)
module uart_sec_tick #(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_BYTES = 2
) (
  input  logic                   clk_50m,
  input  logic                   reset_n,
  output logic                   tick,
  output logic [CNT_BYTES*8-1:0] count
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = CNT_BYTES * 8;
  logic [PW-1:0] presc;
  assign tick = presc == PW'(CLK_DIV - 1);
  always_ff @(posedge clk_50m or negedge reset_n)
    if (!reset_n) begin
      presc <= '0;
      count <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      count <= count + CW'(tick);
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART command decoder driving led[LED_NUM] and framed seconds/report transmitter; in clk_50m, reset_n, uart_rx_data/uart_rx_done, uart_tx_busy; out uart_tx_data/uart_tx_enable, led
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int LED_NUM = 6,
  parameter int CNT_BYTES = 2
) (
  input  logic               clk_50m,
  input  logic               reset_n,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_done,
  input  logic               uart_tx_busy,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_enable,
  output logic [LED_NUM-1:0] led
);
  localparam int RPT_BYTES = (LED_NUM + 7) / 8;
  localparam int NB = (CNT_BYTES > RPT_BYTES ? CNT_BYTES : RPT_BYTES) + 1;
  localparam int FW = NB * 8;
  logic                   tick;
  logic [CNT_BYTES*8-1:0] count;
  logic [1:0]             op;
  logic [5:0]             idx;
  logic                   hit, rpt_req;
  logic [LED_NUM-1:0]     mask, led_nxt;
  tx_state_t              state;
  logic                   cnt_pend, rpt_pend, skip, start_cnt, start_rpt;
  logic [2:0]             rem;
  logic [FW-1:0]          shift, cnt_img, rpt_img;

  uart_sec_tick #(.CLK_DIV(CLK_DIV), .CNT_BYTES(CNT_BYTES)) u_tick (
    .clk_50m(clk_50m),
    .reset_n(reset_n),
    .tick(tick),
    .count(count)
  );

  assign op = uart_rx_data[7:6];
  assign idx = uart_rx_data[5:0];
  assign hit = idx < 6'(LED_NUM);
  assign mask = LED_NUM'(1) << idx;
  assign rpt_req = uart_rx_done && op == OP_SYS && idx == SYS_REPORT;
  assign led_nxt = !uart_rx_done ? led
                 : op == OP_SYS ? (idx == SYS_ALL_OFF ? '0 : idx == SYS_ALL_ON ? '1 : led)
                 : !hit ? led
                 : op == OP_TGL ? led ^ mask
                 : op == OP_SET ? led | mask
                 : led & ~mask;

  assign start_cnt = state == IDLE && cnt_pend;
  assign start_rpt = state == IDLE && !cnt_pend && rpt_pend;
  assign cnt_img = FW'({HDR_CNT, count}) << (8 * (NB - 1 - CNT_BYTES));
  assign rpt_img = FW'({HDR_RPT, (RPT_BYTES * 8)'(led)}) << (8 * (NB - 1 - RPT_BYTES));

  always_ff @(posedge clk_50m or negedge reset_n)
    if (!reset_n) led <= '0;
    else led <= led_nxt;

  always_ff @(posedge clk_50m or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      cnt_pend       <= 1'b0;
      rpt_pend       <= 1'b0;
      shift          <= '0;
      rem            <= '0;
      skip           <= 1'b0;
      uart_tx_data   <= '0;
      uart_tx_enable <= 1'b0;
    end else begin
      cnt_pend       <= tick | (cnt_pend & ~start_cnt);
      rpt_pend       <= rpt_req | (rpt_pend & ~start_rpt);
      uart_tx_enable <= 1'b0;
      case (state)
        IDLE:
          if (start_cnt | start_rpt) begin
            shift <= start_cnt ? cnt_img : rpt_img;
            rem   <= start_cnt ? 3'(CNT_BYTES) : 3'(RPT_BYTES);
            state <= LOAD;
          end
        LOAD:
          if (!uart_tx_busy) begin
            uart_tx_data   <= shift[FW-1 -: 8];
            uart_tx_enable <= 1'b1;
            state          <= STROBE;
          end
        STROBE: begin
          skip  <= 1'b0;
          state <= WAIT_HI;
        end
        WAIT_HI:
          if (uart_tx_busy | skip) state <= WAIT_LO;
          else skip <= 1'b1;
        WAIT_LO:
          if (!uart_tx_busy) begin
            shift <= shift << 8;
            rem   <= rem - 3'd1;
            state <= rem == 3'd0 ? IDLE : LOAD;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized scoreboard bench for uart_cmd_ctrl with a frame-level reference model and busy model
module tb_uart_cmd_ctrl;
  localparam int CLK_DIV = 200;
  logic       clk_50m = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_done = 1'b0;
  logic       uart_tx_busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_enable;
  logic [5:0] led;
  int checks = 0, passes = 0;
  int cyc = 0, ticks = 0, bcnt = 0, busy_len = 20;
  logic [5:0]  m_led = '0;
  logic [15:0] cnt_v;
  logic [8:0]  e_v;
  logic [8:0]  exp_tx[$];
  logic [5:0]  exp_led[$];
  bit rpt_out = 0, led_chk = 0, prev_en = 0;

  uart_cmd_ctrl #(.CLK_DIV(CLK_DIV), .LED_NUM(6), .CNT_BYTES(2)) dut (
    .clk_50m(clk_50m),
    .reset_n(reset_n),
    .uart_rx_data(uart_rx_data),
    .uart_rx_done(uart_rx_done),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_data(uart_tx_data),
    .uart_tx_enable(uart_tx_enable),
    .led(led)
  );

  always #10 clk_50m = ~clk_50m;

  assign uart_tx_busy = bcnt != 0;
  always @(posedge clk_50m)
    if (!reset_n) bcnt <= 0;
    else if (uart_tx_enable) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_50m) begin
    led_chk <= reset_n && uart_rx_done;
    if (!reset_n) begin
      cyc = 0;
      ticks = 0;
    end else begin
      if (cyc % CLK_DIV == CLK_DIV - 1) begin
        ticks = ticks + 1;
        cnt_v = 16'(ticks);
        exp_tx.push_back({1'b0, 8'h5A});
        exp_tx.push_back({1'b0, cnt_v[15:8]});
        exp_tx.push_back({1'b0, cnt_v[7:0]});
      end
      if (uart_rx_done && uart_rx_data == 8'hC2) begin
        exp_tx.push_back({1'b1, 8'hA5});
        exp_tx.push_back({3'b000, m_led});
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk_50m) begin
    if (led_chk) begin
      if (exp_led.size() == 0) check("led_unexpected", 32'd1, 32'd0);
      else check("led", 32'(led), 32'(exp_led.pop_front()));
    end
    if (uart_tx_enable) begin
      check("tx_en_while_busy", 32'(uart_tx_busy), 32'd0);
      check("tx_en_width", 32'(prev_en), 32'd0);
      if (exp_tx.size() == 0) begin
        checks++;
        $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", uart_tx_data);
      end else begin
        e_v = exp_tx.pop_front();
        check("tx_byte", 32'(uart_tx_data), 32'(e_v[7:0]));
        if (e_v[8]) rpt_out = 0;
      end
    end
    prev_en = uart_tx_enable;
  end

  task automatic send(input logic [7:0] b);
    logic [1:0] op;
    logic [5:0] idx;
    op = b[7:6];
    idx = b[5:0];
    if (op == 2'd3) begin
      if (idx == 6'd0) m_led = 6'h00;
      else if (idx == 6'd1) m_led = 6'h3F;
      else if (idx == 6'd2) rpt_out = 1;
    end else if (idx < 6'd6) begin
      if (op == 2'd0) m_led = m_led ^ (6'd1 << idx);
      else if (op == 2'd1) m_led = m_led | (6'd1 << idx);
      else m_led = m_led & ~(6'd1 << idx);
    end
    exp_led.push_back(m_led);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    @(negedge clk_50m);
    uart_rx_done = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    do @(negedge clk_50m); while (cyc % CLK_DIV != ph);
  endtask

  task automatic wait_rpt();
    int n = 0;
    while (rpt_out && n < 2000) begin
      @(negedge clk_50m);
      n++;
    end
    if (rpt_out) begin
      checks++;
      $display("FAIL rpt_timeout: report header not seen after %0d cycles, expected within 2000", n);
      rpt_out = 0;
    end
  endtask

  initial begin
    int r, n;
    repeat (3) @(negedge clk_50m);
    check("rst_led", 32'(led), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    check("rst_tx_en", 32'(uart_tx_enable), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_50m);
    send(8'h00);
    send(8'h43);
    send(8'h80);
    send(8'h07);
    send(8'h3F);
    send(8'hC1);
    send(8'hC0);
    wait_phase(80);
    send(8'hC0);
    send(8'h40);
    send(8'h42);
    send(8'h43);
    send(8'h45);
    send(8'hC2);
    wait_rpt();
    send(8'h00);
    wait_phase(CLK_DIV - 1);
    send(8'hC2);
    wait_rpt();
    wait_phase(150);
    busy_len = 100;
    wait_phase(CLK_DIV - 1);
    wait_phase(CLK_DIV - 1);
    wait_phase(50);
    busy_len = 20;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk_50m);
      if (!rpt_out) begin
        r = $urandom_range(0, 9);
        if (r < 2) send(8'hC0 | 8'($urandom_range(0, 3)));
        else send({2'($urandom_range(0, 2)), 6'($urandom_range(0, 7))});
      end
    end
    wait_rpt();
    send(8'hC1);
    wait_phase(CLK_DIV - 1);
    repeat (30) @(negedge clk_50m);
    reset_n = 1'b0;
    #1;
    check("midframe_rst_tx_en", 32'(uart_tx_enable), 32'd0);
    check("midframe_rst_led", 32'(led), 32'd0);
    check("midframe_rst_tx_data", 32'(uart_tx_data), 32'd0);
    exp_tx.delete();
    exp_led.delete();
    m_led = '0;
    rpt_out = 0;
    repeat (3) @(negedge clk_50m);
    reset_n = 1'b1;
    n = 0;
    while ((cyc < CLK_DIV + 80 || exp_tx.size() != 0) && n < 1500) begin
      @(negedge clk_50m);
      n++;
    end
    if (exp_tx.size() != 0 || cyc < CLK_DIV + 80) begin
      checks++;
      $display("FAIL drain_timeout: %0d bytes still expected, required 0", exp_tx.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion earlier");
    $fatal(1);
  end
endmodule
